// File: rtl/riscv_32_fetch_stage_pkg.sv
// Shared CPU package for the 32-bit RISC-V pipeline.
//   fetch_state_e  : fetch-stage FSM states (BOOT / RUN / SKID)
//   INSTR_NOP      : canonical NOP (addi x0,x0,0), used as the "no instruction" word
//   FETCH_RESET_PC : default PC of the first fetch after reset
//   PC_STEP        : byte distance between consecutive 32-bit instructions
//   pc_next()      : sequential PC increment, wraps modulo 2^32
package riscv_32_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,  // issue the first request for fetch_pc, nothing in flight yet
    FS_RUN  = 2'd1,  // one response in flight, streaming
    FS_SKID = 2'd2   // response parked in the skid regs while downstream stalls
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP        = 32'd4;

  // Plain 32-bit add: carry out is dropped, so FFFF_FFFC steps to 0000_0000.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/riscv_32_fetch_stage.sv
// Instruction fetch stage for a 32-bit RISC-V core.
// Streams one instruction per cycle from an external synchronous instruction
// memory (1-cycle read latency) into the decode stage, absorbs downstream
// stalls with a one-entry skid buffer, and restarts on branch/jump redirects.
//
// Ports:
//   clk          : clock, all state changes on the rising edge
//   rst_n        : synchronous active-low reset
//   imem_en      : instruction-memory read request this cycle
//   imem_addr    : word address of the request (fetch_pc[IMEM_AW+1:2])
//   imem_rdata   : read data, valid the cycle after imem_en
//   stall        : decode cannot accept; instr_d/pc_d/valid_d hold
//   redirect     : taken branch / jump, flushes the stage (wins over stall)
//   redirect_pc  : new fetch target; low two bits are dropped
//   instr_d      : instruction word to decode
//   pc_d         : PC of instr_d
//   valid_d      : instr_d/pc_d carry a real instruction
//   misalign     : one-cycle pulse after a redirect whose target had pc[1:0] != 0
module riscv_32_fetch_stage
  import riscv_32_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc_d,
  output logic               valid_d,
  output logic               misalign
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;    // PC of the next request to issue
  logic [31:0]  rsp_pc;      // PC of the request whose data arrives this cycle
  logic [31:0]  skid_instr;  // response captured while decode was stalled
  logic [31:0]  skid_pc;

  // The request strobe has to be combinational: the memory samples it in the
  // same cycle the FSM decides whether it can take the response next cycle.
  // BOOT always requests (nothing is in flight to protect); RUN and SKID only
  // request when decode is moving, otherwise the in-flight word would be
  // overwritten before it is consumed. A request made in a redirect cycle is
  // harmless: BOOT never looks at imem_rdata.
  assign imem_en   = rst_n && ((state == FS_BOOT) || !stall);
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FS_BOOT;
      fetch_pc   <= RESET_PC;
      rsp_pc     <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      instr_d    <= INSTR_NOP;
      pc_d       <= '0;
      valid_d    <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      misalign <= redirect && (redirect_pc[1:0] != 2'b00);

      if (redirect) begin
        // Flush: the in-flight response and any skid contents are simply
        // never read again, BOOT re-primes the pipe from the new target.
        state    <= FS_BOOT;
        valid_d  <= 1'b0;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else begin
        unique case (state)
          FS_BOOT: begin
            rsp_pc   <= fetch_pc;
            fetch_pc <= pc_next(fetch_pc);
            state    <= FS_RUN;
          end

          FS_RUN: begin
            if (!stall) begin
              instr_d  <= imem_rdata;
              pc_d     <= rsp_pc;
              valid_d  <= 1'b1;
              rsp_pc   <= fetch_pc;
              fetch_pc <= pc_next(fetch_pc);
            end else begin
              // imem_rdata is only valid this one cycle, so park it.
              skid_instr <= imem_rdata;
              skid_pc    <= rsp_pc;
              state      <= FS_SKID;
            end
          end

          FS_SKID: begin
            if (!stall) begin
              // Hand over the parked word and restart the request stream in
              // the same cycle so throughput stays at one per cycle.
              instr_d  <= skid_instr;
              pc_d     <= skid_pc;
              valid_d  <= 1'b1;
              rsp_pc   <= fetch_pc;
              fetch_pc <= pc_next(fetch_pc);
              state    <= FS_RUN;
            end
          end

          default: state <= FS_BOOT;
        endcase
      end
    end
  end

endmodule
